// File: rtl/bus_interface_unit_if.sv
// bus_interface_unit_if: core-side request/response bundle for bus_interface_unit.
// The core drives the request fields; the unit returns ack/busy/done/rdata.
interface bus_interface_unit_if #(
   parameter int ADDR_W = 16,
   parameter int BUS_W  = 8,
   parameter int BEATS  = 2,
   parameter int WAIT_W = 3
);
   logic                   req;
   logic                   we;
   logic [ADDR_W-1:0]      req_addr;
   logic [BUS_W*BEATS-1:0] req_wdata;
   logic [WAIT_W-1:0]      wait_states;
   logic                   ack;
   logic                   busy;
   logic                   done;
   logic [BUS_W*BEATS-1:0] rdata;
   modport master (
      output req, we, req_addr, req_wdata, wait_states,
      input  ack, busy, done, rdata
   );
   modport slave (
      input  req, we, req_addr, req_wdata, wait_states,
      output ack, busy, done, rdata
   );
endinterface

// File: rtl/bus_interface_unit.sv
// bus_interface_unit: runs one core word as BEATS external bus beats with wait states.
// Optional BIU_TURNAROUND_EN inserts one idle TURN cycle when the transfer direction flips.
module bus_interface_unit #(
   parameter int ADDR_W = 16,
   parameter int BUS_W  = 8,
   parameter int BEATS  = 2,
   parameter int WAIT_W = 3
) (
   input  logic                ph1,
   input  logic                reset,
   bus_interface_unit_if.slave core,
   output logic [ADDR_W-1:0]   address,
   inout  wire  [BUS_W-1:0]    data,
   output logic                read_en
);
   localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
   typedef enum logic [1:0] {IDLE, TURN, BEAT, DONE} state_t;
   state_t                 state, nxt;
   logic [BW-1:0]          b;
   logic [WAIT_W-1:0]      w, wait_q;
   logic                   we_q, turn, last_beat, beat_end, drive;
   logic [BUS_W*BEATS-1:0] wdata_q, rdata_q;
`ifdef BIU_TURNAROUND_EN
   logic                   dir_q;
   assign turn = core.we != dir_q;
`else
   assign turn = 1'b0;
`endif
   assign core.ack  = core.req && state == IDLE && !reset;
   assign core.busy = state != IDLE;
   assign core.done = state == DONE;
   assign core.rdata = rdata_q;
   assign last_beat = b == BW'(BEATS - 1);
   assign beat_end  = state == BEAT && w == '0;
   assign drive     = state == BEAT && we_q;
   assign read_en   = !drive;
   assign data      = drive ? wdata_q[b*BUS_W +: BUS_W] : 'z;
   always_ff @(posedge ph1 or posedge reset)
      if (reset) state <= IDLE;
      else       state <= nxt;
   always_comb begin
      nxt = state;
      nxt = state == IDLE ? (core.ack ? (turn ? TURN : BEAT) : IDLE) :
            state == TURN ? BEAT :
            state == BEAT ? (beat_end && last_beat ? DONE : BEAT) : IDLE;
   end
   // address is loaded with the base at accept, so TURN already shows it
   always_ff @(posedge ph1 or posedge reset)
      if (reset) begin
         address <= '0;
         b       <= '0;
         w       <= '0;
         wait_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef BIU_TURNAROUND_EN
         dir_q   <= 1'b0;
`endif
      end else if (state == IDLE && core.ack) begin
         address <= core.req_addr;
         b       <= '0;
         w       <= core.wait_states;
         wait_q  <= core.wait_states;
         we_q    <= core.we;
         wdata_q <= core.req_wdata;
`ifdef BIU_TURNAROUND_EN
         dir_q   <= core.we;
`endif
      end else if (state == BEAT) begin
         if (w != '0) w <= w - 1'b1;
         else begin
            if (!we_q) rdata_q[b*BUS_W +: BUS_W] <= data;
            if (!last_beat) begin
               b       <= b + 1'b1;
               w       <= wait_q;
               address <= address + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_bus_interface_unit.sv
// tb_bus_interface_unit: directed and randomized transfers checked against a cycle timeline
// derived from beat count, wait states and direction history.
module tb_bus_interface_unit;
   localparam int ADDR_W = 16, BUS_W = 8, BEATS = 2, WAIT_W = 3;
   logic              ph1 = 1'b0;
   logic              reset = 1'b0;
   logic [ADDR_W-1:0] address;
   logic              read_en;
   wire  [BUS_W-1:0]  data;
   logic [7:0]        mem [65536];
   logic [15:0]       exp_rdata = '0;
   logic              last_dir = 1'b0;
   int                vec = 0, err = 0;
   bus_interface_unit_if #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .BEATS(BEATS), .WAIT_W(WAIT_W)) bus ();
   bus_interface_unit #(.ADDR_W(ADDR_W), .BUS_W(BUS_W), .BEATS(BEATS), .WAIT_W(WAIT_W)) dut (
      .ph1(ph1), .reset(reset), .core(bus.slave), .address(address), .data(data), .read_en(read_en)
   );
   // external device answers from its memory whenever the pad is released
   assign data = read_en ? mem[address] : 8'bz;
   always #5 ph1 = ~ph1;

   task automatic do_xfer(input logic w_e, input logic [15:0] a, input logic [15:0] wd,
                          input logic [2:0] ws, input bit hold, input string tag);
      bit t;
      logic [15:0] ea, nr;
      bus.req = 1'b1; bus.we = w_e; bus.req_addr = a; bus.req_wdata = wd; bus.wait_states = ws;
      #1;
      vec++; if (bus.ack !== 1'b1) begin err++; $display("FAIL %s ack_idle: got %b want 1", tag, bus.ack); end
      t = 1'b0;
`ifdef BIU_TURNAROUND_EN
      t = w_e != last_dir;
`endif
      last_dir = w_e;
      nr = exp_rdata;
      if (!w_e) for (int k = 0; k < BEATS; k++) nr[k*8 +: 8] = mem[a + 16'(k)];
      @(posedge ph1); #1;
      if (!hold) bus.req = 1'b0;
      if (t) begin
         @(negedge ph1);
         vec++; if (bus.busy !== 1'b1 || read_en !== 1'b1 || address !== a || bus.done !== 1'b0) begin
            err++; $display("FAIL %s turn: busy=%b re=%b addr=%h done=%b want 1 1 %h 0", tag, bus.busy, read_en, address, bus.done, a);
         end
      end
      for (int k = 0; k < BEATS; k++)
         for (int c = 0; c <= int'(ws); c++) begin
            @(negedge ph1);
            ea = a + 16'(k);
            vec++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || address !== ea || read_en !== !w_e) begin
               err++; $display("FAIL %s beat%0d.%0d: busy=%b done=%b addr=%h re=%b want 1 0 %h %b", tag, k, c, bus.busy, bus.done, address, read_en, ea, !w_e);
            end
            if (w_e) begin
               vec++; if (data !== wd[k*8 +: 8]) begin err++; $display("FAIL %s wdata%0d.%0d: got %h want %h", tag, k, c, data, wd[k*8 +: 8]); end
            end
            if (hold) begin
               vec++; if (bus.ack !== 1'b0) begin err++; $display("FAIL %s ack_busy: got %b want 0", tag, bus.ack); end
            end
         end
      @(negedge ph1);
      exp_rdata = nr;
      vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || read_en !== 1'b1 || bus.rdata !== exp_rdata) begin
         err++; $display("FAIL %s done: done=%b busy=%b re=%b rdata=%h want 1 1 1 %h", tag, bus.done, bus.busy, read_en, bus.rdata, exp_rdata);
      end
      @(negedge ph1);
      vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== exp_rdata) begin
         err++; $display("FAIL %s idle: done=%b busy=%b rdata=%h want 0 0 %h", tag, bus.done, bus.busy, bus.rdata, exp_rdata);
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #1;
      vec++; if (address !== 16'h0 || read_en !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rdata !== 16'h0) begin
         err++; $display("FAIL reset: addr=%h re=%b busy=%b done=%b rdata=%h want 0000 1 0 0 0000", address, read_en, bus.busy, bus.done, bus.rdata);
      end
      @(negedge ph1); reset = 1'b0;
      exp_rdata = '0; last_dir = 1'b0;
      @(negedge ph1);
   endtask

   task automatic test_read();
      mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
      do_xfer(1'b0, 16'h1234, 16'h0, 3'd0, 1'b0, "read");
      vec++; if (bus.rdata !== 16'hABCD) begin err++; $display("FAIL read_abcd: got %h want abcd", bus.rdata); end
   endtask

   task automatic test_write_wrap();
      do_xfer(1'b1, 16'hFFFF, 16'hBEEF, 3'd2, 1'b0, "wrwrap");
   endtask

   task automatic test_turnaround();
      do_xfer(1'b1, 16'h0010, 16'h5A5A, 3'd0, 1'b0, "ta_wr");
      mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;
      do_xfer(1'b0, 16'h0020, 16'h0, 3'd0, 1'b0, "ta_rd");
   endtask

   task automatic test_abort();
      bit t;
      bus.req = 1'b1; bus.we = 1'b1; bus.req_addr = 16'h4000; bus.req_wdata = 16'hC3A5; bus.wait_states = 3'd1;
      t = 1'b0;
`ifdef BIU_TURNAROUND_EN
      t = last_dir != 1'b1;
`endif
      @(posedge ph1); #1 bus.req = 1'b0;
      repeat (int'(t) + 3) @(negedge ph1);
      vec++; if (address !== 16'h4001 || read_en !== 1'b0 || data !== 8'hC3) begin
         err++; $display("FAIL abort_pre: addr=%h re=%b data=%h want 4001 0 c3", address, read_en, data);
      end
      reset = 1'b1;
      #1;
      exp_rdata = '0; last_dir = 1'b0;
      vec++; if (read_en !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || address !== 16'h0 || bus.rdata !== 16'h0) begin
         err++; $display("FAIL abort: re=%b busy=%b done=%b addr=%h rdata=%h want 1 0 0 0000 0000", read_en, bus.busy, bus.done, address, bus.rdata);
      end
      @(negedge ph1); reset = 1'b0;
      repeat (3) begin
         @(negedge ph1);
         vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin err++; $display("FAIL abort_nodone: done=%b busy=%b want 0 0", bus.done, bus.busy); end
      end
      mem[16'h0300] = 8'h77; mem[16'h0301] = 8'h88;
      do_xfer(1'b0, 16'h0300, 16'h0, 3'd0, 1'b0, "post_abort");
   endtask

   task automatic test_back_to_back();
      mem[16'h0500] = 8'h3C; mem[16'h0501] = 8'h4D;
      do_xfer(1'b1, 16'h0400, 16'h1357, 3'd1, 1'b1, "b2b_1");
      do_xfer(1'b0, 16'h0500, 16'h0, 3'd0, 1'b0, "b2b_2");
   endtask

   task automatic test_random();
      logic w_e;
      logic [15:0] a, wd;
      logic [2:0] ws;
      for (int i = 0; i < 24; i++) begin
         w_e = 1'($urandom); a = 16'($urandom); wd = 16'($urandom); ws = 3'($urandom_range(0, 7));
         if (i % 6 == 0) a = 16'hFFFF;
         for (int k = 0; k < BEATS; k++) mem[a + 16'(k)] = 8'($urandom);
         do_xfer(w_e, a, wd, ws, 1'($urandom_range(0, 1)), "rand");
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
      bus.req = 1'b0; bus.we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.wait_states = '0;
      test_reset();
      test_read();
      test_write_wrap();
      test_turnaround();
      test_abort();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
